// File: rtl/bus_uart_pkg.sv
// Shared constants and types for the memory-mapped 8N1 UART on the 65C02 bus.
package bus_uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIVLO  = 2'd2;
  localparam logic [1:0] REG_DIVHI  = 2'd3;

  localparam int ST_RX_FULL   = 0;
  localparam int ST_TX_IDLE   = 1;
  localparam int ST_TX_FULL   = 2;
  localparam int ST_RX_OVR    = 3;
  localparam int ST_FRAME_ERR = 4;
  localparam int ST_TX_DROP   = 5;

  // 50 MHz system clock divided down to 115200 baud
  localparam logic [15:0] DIV_DEFAULT_115200 = 16'd434;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  function automatic logic [15:0] eff_div(input logic [15:0] n);
    return (n < 16'd2) ? 16'd2 : n;
  endfunction

endpackage

// File: rtl/bus_uart_if.sv
// CPU bus signals seen by a memory-mapped responder: address/write strobe in, registered read data out.
interface bus_uart_if;
  logic [15:0] ab;
  logic        we;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        rsel;

  modport master (output ab, we, wdata, input rdata, rsel);
  modport slave  (input ab, we, wdata, output rdata, rsel);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; a push while full is accepted only if a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/bus_uart.sv
// 8N1 UART responding in a 4-byte window on the CPU bus: DATA, STATUS, DIV_LO, DIV_HI.
module bus_uart
  import bus_uart_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h8000,
  parameter logic [15:0] DIV_RESET = DIV_DEFAULT_115200,
  parameter int          TX_DEPTH  = 16
) (
  input  logic       clk,
  input  logic       reset,
  bus_uart_if.slave  bus,
  output logic       irq,
  output logic       txd,
  input  logic       rxd
);
  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic       hit, rd_hit, wr_hit;
  logic [1:0] off;
  logic       data_rd, data_wr, status_wr, divlo_wr, divhi_wr;

  assign hit       = (bus.ab[15:2] == BASE_ADDR[15:2]);
  assign off       = bus.ab[1:0];
  assign rd_hit    = hit && !bus.we;
  assign wr_hit    = hit && bus.we;
  assign data_rd   = rd_hit && (off == REG_DATA);
  assign data_wr   = wr_hit && (off == REG_DATA);
  assign status_wr = wr_hit && (off == REG_STATUS);
  assign divlo_wr  = wr_hit && (off == REG_DIVLO);
  assign divhi_wr  = wr_hit && (off == REG_DIVHI);

  logic [15:0] div_q, div_d, n_eff;
  logic [7:0]  rx_hold_q, rx_hold_d;
  logic        rx_full_q, rx_full_d;
  logic        rx_ovr_q, rx_ovr_d;
  logic        frame_err_q, frame_err_d;
  logic        tx_drop_q, tx_drop_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rsel_q, rsel_d;
  logic [7:0]  status;

  assign n_eff = eff_div(div_q);

  logic [7:0]    fifo_dout;
  logic          fifo_full, fifo_empty, tx_pop, tx_idle;
  logic [CW-1:0] fifo_count;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (data_wr),
    .din   (bus.wdata),
    .pop   (tx_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ---------------- TX serializer ----------------
  tx_state_t   tx_state_q;
  logic [15:0] tx_cnt_q;
  logic [2:0]  tx_bit_q;
  logic [7:0]  tx_shift_q;
  logic        txd_q, tx_cnt_done;

  assign tx_cnt_done = (tx_cnt_q == 16'd0);
  // Popping at the end of STOP chains frames with no idle gap between them.
  assign tx_pop  = !fifo_empty && ((tx_state_q == TX_IDLE) || ((tx_state_q == TX_STOP) && tx_cnt_done));
  assign tx_idle = (fifo_count == '0) && (tx_state_q == TX_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else if (tx_pop) begin
      tx_state_q <= TX_START;
      tx_shift_q <= fifo_dout;
      tx_cnt_q   <= n_eff - 16'd1;
      txd_q      <= 1'b0;
    end else begin
      case (tx_state_q)
        TX_IDLE: txd_q <= 1'b1;
        TX_START: begin
          if (tx_cnt_done) begin
            tx_state_q <= TX_DATA;
            txd_q      <= tx_shift_q[0];
            tx_shift_q <= tx_shift_q >> 1;
            tx_bit_q   <= '0;
            tx_cnt_q   <= n_eff - 16'd1;
          end else tx_cnt_q <= tx_cnt_q - 16'd1;
        end
        TX_DATA: begin
          if (tx_cnt_done) begin
            tx_cnt_q <= n_eff - 16'd1;
            if (tx_bit_q == 3'd7) begin
              tx_state_q <= TX_STOP;
              txd_q      <= 1'b1;
            end else begin
              txd_q      <= tx_shift_q[0];
              tx_shift_q <= tx_shift_q >> 1;
              tx_bit_q   <= tx_bit_q + 3'd1;
            end
          end else tx_cnt_q <= tx_cnt_q - 16'd1;
        end
        TX_STOP: begin
          if (tx_cnt_done) tx_state_q <= TX_IDLE;
          else             tx_cnt_q   <= tx_cnt_q - 16'd1;
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  // ---------------- RX deserializer ----------------
  rx_state_t   rx_state_q;
  logic [15:0] rx_cnt_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_shift_q;
  logic        rx_s1_q, rx_s2_q, rx_s3_q;
  logic        rx_fall, rx_cnt_done, rx_done;

  assign rx_fall     = rx_s3_q && !rx_s2_q;
  assign rx_cnt_done = (rx_cnt_q == 16'd0);
  assign rx_done     = (rx_state_q == RX_STOP) && rx_cnt_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_s1_q <= rxd;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_state_q <= RX_START;
            rx_cnt_q   <= (n_eff >> 1) - 16'd1;
          end
        end
        RX_START: begin
          if (rx_cnt_done) begin
            if (rx_s2_q) rx_state_q <= RX_IDLE;
            else begin
              rx_state_q <= RX_DATA;
              rx_bit_q   <= '0;
              rx_cnt_q   <= n_eff - 16'd1;
            end
          end else rx_cnt_q <= rx_cnt_q - 16'd1;
        end
        RX_DATA: begin
          if (rx_cnt_done) begin
            rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
            rx_cnt_q   <= n_eff - 16'd1;
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
            else                  rx_bit_q   <= rx_bit_q + 3'd1;
          end else rx_cnt_q <= rx_cnt_q - 16'd1;
        end
        RX_STOP: begin
          if (rx_cnt_done) rx_state_q <= RX_IDLE;
          else             rx_cnt_q   <= rx_cnt_q - 16'd1;
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // ---------------- Register file ----------------
  always_comb begin
    status               = '0;
    status[ST_RX_FULL]   = rx_full_q;
    status[ST_TX_IDLE]   = tx_idle;
    status[ST_TX_FULL]   = fifo_full;
    status[ST_RX_OVR]    = rx_ovr_q;
    status[ST_FRAME_ERR] = frame_err_q;
    status[ST_TX_DROP]   = tx_drop_q;
  end

  always_comb begin
    div_d       = div_q;
    rx_hold_d   = rx_hold_q;
    rx_full_d   = rx_full_q;
    rx_ovr_d    = rx_ovr_q;
    frame_err_d = frame_err_q;
    tx_drop_d   = tx_drop_q;
    rsel_d      = rd_hit;
    rdata_d     = '0;

    if (rd_hit) begin
      case (off)
        REG_DATA:   rdata_d = rx_hold_q;
        REG_STATUS: rdata_d = status;
        REG_DIVLO:  rdata_d = div_q[7:0];
        REG_DIVHI:  rdata_d = div_q[15:8];
      endcase
    end

    if (data_rd)  rx_full_d    = 1'b0;
    if (divlo_wr) div_d[7:0]   = bus.wdata;
    if (divhi_wr) div_d[15:8]  = bus.wdata;
    if (status_wr) begin
      rx_ovr_d    = 1'b0;
      frame_err_d = 1'b0;
      tx_drop_d   = 1'b0;
    end

    // Sticky events are applied after the clear so they win a same-cycle STATUS write.
    if (data_wr && fifo_full && !tx_pop) tx_drop_d = 1'b1;
    if (rx_done) begin
      if (!rx_full_q || data_rd) begin
        rx_hold_d = rx_shift_q;
        rx_full_d = 1'b1;
      end else rx_ovr_d = 1'b1;
      if (!rx_s2_q) frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q       <= DIV_RESET;
      rx_hold_q   <= '0;
      rx_full_q   <= 1'b0;
      rx_ovr_q    <= 1'b0;
      frame_err_q <= 1'b0;
      tx_drop_q   <= 1'b0;
      rdata_q     <= '0;
      rsel_q      <= 1'b0;
    end else begin
      div_q       <= div_d;
      rx_hold_q   <= rx_hold_d;
      rx_full_q   <= rx_full_d;
      rx_ovr_q    <= rx_ovr_d;
      frame_err_q <= frame_err_d;
      tx_drop_q   <= tx_drop_d;
      rdata_q     <= rdata_d;
      rsel_q      <= rsel_d;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.rsel  = rsel_q;
  assign irq       = rx_full_q;
  assign txd       = txd_q;

endmodule

// File: tb/tb_bus_uart.sv
// Self-checking bench for bus_uart: directed steps plus random bytes against a register-level UART model.
module tb_bus_uart;

  localparam int          DEPTH = 16;
  localparam logic [15:0] BASE  = 16'h8000;
  localparam logic [15:0] DIVR  = 16'd434;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rxd = 1'b1;
  logic irq, txd;

  bus_uart_if bus();

  bus_uart #(.BASE_ADDR(BASE), .DIV_RESET(DIVR), .TX_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .irq   (irq),
    .txd   (txd),
    .rxd   (rxd)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int tb_n  = 434;            // effective bit period used by the serial driver and monitor
  logic [8:0] tx_got[$];      // {stop, data} of each frame seen on txd
  logic [8:0] mon_f;

  // Behavioural model of the receive-side and sticky status bits
  logic       m_full, m_ovr, m_ferr, m_drop;
  logic [7:0] m_hold;

  function automatic logic [7:0] m_status(input logic tx_idle, input logic tx_full);
    return {2'b00, m_drop, m_ferr, m_ovr, tx_full, tx_idle, m_full};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.ab = a; bus.we = 1'b1; bus.wdata = d;
    @(negedge clk);
    bus.we = 1'b0; bus.ab = 16'h0000;
    check("rsel after write", bus.rsel, 1'b0);
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.ab = a; bus.we = 1'b0;
    @(negedge clk);
    d = bus.rdata;
    check("rsel after read", bus.rsel, 1'b1);
    bus.ab = 16'h0000;
  endtask

  task automatic read_check(input string tag, input logic [15:0] a, input logic [7:0] exp);
    logic [7:0] d;
    bus_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic read_data_check(input string tag);
    read_check(tag, BASE, m_hold);
    m_full = 1'b0;
  endtask

  task automatic status_clear();
    bus_write(BASE + 16'd1, 8'hFF);
    m_ovr = 1'b0; m_ferr = 1'b0; m_drop = 1'b0;
  endtask

  task automatic set_div(input logic [15:0] n);
    bus_write(BASE + 16'd2, n[7:0]);
    bus_write(BASE + 16'd3, n[15:8]);
    tb_n = (n < 16'd2) ? 2 : int'(n);
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop);
    if (!m_full) begin
      m_hold = b;
      m_full = 1'b1;
    end else m_ovr = 1'b1;
    if (!stop) m_ferr = 1'b1;
  endtask

  // Drives one frame on rxd, then idles long enough for the latency bound; lat = clocks to irq.
  task automatic send_rx(input logic [7:0] b, input logic stop, output int lat);
    logic [9:0] fr;
    int k;
    fr  = {stop, b, 1'b0};
    k   = 0;
    lat = -1;
    @(negedge clk);
    for (int s = 0; s < 10; s++) begin
      rxd = fr[s];
      repeat (tb_n) begin
        @(negedge clk);
        k++;
        if (lat < 0 && irq) lat = k;
      end
    end
    rxd = 1'b1;
    while (k < tb_n / 2 + 9 * tb_n + 6) begin
      @(negedge clk);
      k++;
      if (lat < 0 && irq) lat = k;
    end
  endtask

  task automatic wait_tx(input int n, input int budget);
    int c;
    c = 0;
    while (tx_got.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("tx frame count", 16'(tx_got.size()), 16'(n));
  endtask

  task automatic check_frame(input string tag, input logic [7:0] b);
    logic [8:0] f;
    if (tx_got.size() > 0) begin
      f = tx_got.pop_front();
      check(tag, f, {1'b1, b});
    end
  endtask

  // Serial monitor: finds a start bit and samples each bit near its centre.
  always begin
    @(negedge clk);
    if (!reset && txd === 1'b0) begin
      repeat (tb_n / 2) @(negedge clk);
      for (int i = 0; i < 9; i++) begin
        repeat (tb_n) @(negedge clk);
        mon_f[i] = txd;
      end
      tx_got.push_back(mon_f);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bytes[$];
    logic [7:0] b, b2;
    logic [9:0] fr;
    logic       stop, was_full;
    int         lat, n_written, n_accept;

    bus.ab = 16'h0000; bus.we = 1'b0; bus.wdata = 8'h00;
    m_full = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_drop = 1'b0; m_hold = 8'h00;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("txd reset", txd, 1'b1);
    check("irq reset", irq, 1'b0);
    check("rsel reset", bus.rsel, 1'b0);
    check("rdata reset", bus.rdata, 8'h00);

    read_check("DATA reset", BASE, m_hold);
    read_check("STATUS reset", BASE + 16'd1, m_status(1'b1, 1'b0));
    read_check("DIVLO reset", BASE + 16'd2, DIVR[7:0]);
    read_check("DIVHI reset", BASE + 16'd3, DIVR[15:8]);

    @(negedge clk);
    bus.ab = BASE + 16'd4; bus.we = 1'b0;
    @(negedge clk);
    check("rsel outside window", bus.rsel, 1'b0);
    bus.ab = 16'h0000;

    // 0xA5 at N=2: exact waveform and latency
    set_div(16'd2);
    tx_got.delete();
    b  = 8'hA5;
    fr = {1'b1, b, 1'b0};
    bus_write(BASE, b);
    check("txd one cycle after write", txd, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("A5 slot %0d", i / 2), txd, fr[i / 2]);
    end
    read_check("STATUS after A5", BASE + 16'd1, m_status(1'b1, 1'b0));
    wait_tx(1, 50);
    check_frame("A5 decoded", b);

    // Random bytes at small divisors, including N below the floor of 2
    for (int i = 0; i < 4; i++) begin
      set_div(16'($urandom_range(0, 5)));
      tx_got.delete();
      b = 8'($urandom);
      bus_write(BASE, b);
      wait_tx(1, 10 * tb_n + 40);
      check_frame($sformatf("tx random n=%0d", tb_n), b);
    end

    // Burst overflow at N=8: shifter takes one byte, FIFO holds DEPTH, the rest drop
    set_div(16'd8);
    tx_got.delete();
    bytes.delete();
    n_written = DEPTH + 2;
    n_accept  = DEPTH + 1;
    for (int i = 0; i < n_written; i++) begin
      b = 8'($urandom);
      bytes.push_back(b);
      bus_write(BASE, b);
    end
    m_drop = (n_written > n_accept);
    read_check("STATUS burst", BASE + 16'd1, m_status(1'b0, 1'b1));
    status_clear();
    read_check("STATUS after clear", BASE + 16'd1, m_status(1'b0, 1'b1));
    wait_tx(n_accept, n_accept * 10 * tb_n + 200);
    for (int i = 0; i < n_accept; i++) check_frame($sformatf("burst byte %0d", i), bytes[i]);
    repeat (12 * tb_n) @(negedge clk);
    check("no extra frame", 16'(tx_got.size()), 16'd0);
    read_check("STATUS after burst", BASE + 16'd1, m_status(1'b1, 1'b0));

    // RX 0x3C at N=8
    send_rx(8'h3C, 1'b1, lat);
    model_frame(8'h3C, 1'b1);
    check("rx latency", (lat > 0) && (lat <= tb_n / 2 + 9 * tb_n + 3), 1'b1);
    check("irq after frame", irq, m_full);
    read_check("STATUS rx full", BASE + 16'd1, m_status(1'b1, 1'b0));
    read_data_check("DATA 3C");
    check("irq after DATA read", irq, 1'b0);

    // Overrun, then a framing error
    b  = 8'($urandom);
    b2 = 8'($urandom);
    send_rx(b, 1'b1, lat);  model_frame(b, 1'b1);
    send_rx(b2, 1'b1, lat); model_frame(b2, 1'b1);
    read_check("STATUS overrun", BASE + 16'd1, m_status(1'b1, 1'b0));
    read_data_check("DATA first byte kept");
    status_clear();
    b = 8'($urandom);
    send_rx(b, 1'b0, lat);
    model_frame(b, 1'b0);
    read_check("STATUS frame err", BASE + 16'd1, m_status(1'b1, 1'b0));
    read_data_check("DATA frame err byte");
    status_clear();

    // Random RX frames at random divisors against the model
    for (int i = 0; i < 8; i++) begin
      set_div(16'($urandom_range(0, 10)));
      b        = 8'($urandom);
      stop     = ($urandom_range(0, 3) != 0);
      was_full = m_full;
      send_rx(b, stop, lat);
      model_frame(b, stop);
      if (!was_full)
        check($sformatf("rx latency n=%0d", tb_n), (lat > 0) && (lat <= tb_n / 2 + 9 * tb_n + 3), 1'b1);
      check("irq random", irq, m_full);
      read_check($sformatf("STATUS random %0d", i), BASE + 16'd1, m_status(1'b1, 1'b0));
      if ($urandom_range(0, 1) == 1) read_data_check($sformatf("DATA random %0d", i));
      if ($urandom_range(0, 2) == 0) status_clear();
    end

    // Reset in the middle of a TX frame
    set_div(16'd8);
    bus_write(BASE, 8'($urandom));
    bus_write(BASE, 8'($urandom));
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("txd after mid-frame reset", txd, 1'b1);
    reset = 1'b0;
    m_full = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_drop = 1'b0; m_hold = 8'h00;
    check("irq after mid-frame reset", irq, 1'b0);
    read_check("STATUS after reset", BASE + 16'd1, m_status(1'b1, 1'b0));
    read_check("DIVLO after reset", BASE + 16'd2, DIVR[7:0]);
    repeat (12 * tb_n) @(negedge clk);
    tx_got.delete();
    set_div(16'd8);
    b = 8'($urandom);
    bus_write(BASE, b);
    wait_tx(1, 12 * tb_n + 20);
    check_frame("tx after reset", b);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
